score_writer: RTL and testbench

//  Sequencer for the "writing" mode of the music box.
//  - Turns switch/key entries into 12-bit score words.
//  - Writes them through the regfile's third (write) port: addr_c / data_c / wen_c.
//  - Closes the song with an end-marker word when writing mode is left.
//  - Sits beside the mode controller; reads back via the existing read/playback path.

---
 rtl/score_writer.sv | 149 ++++++++++++++
 tb/tb_score_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_writer.sv
// Writing-mode sequencer for the music box. It turns switch and key entries into
// 12-bit score words, writes them through the regfile write port, and closes each song with a 12'h000 end marker.
module score_writer #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BASE    = 0,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LEN_DEF = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [15:0]       SW,
  input  logic [2:0]        band_in,
  input  logic              commit,
  input  logic              del,
  input  logic              len_key,
  output logic [ADDR_W-1:0] addr_c,
  output logic [11:0]       data_c,
  output logic              wen_c,
  output logic [ADDR_W-1:0] count,
  output logic [3:0]        len,
  output logic              full,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE + DEPTH - 1);
  localparam logic [3:0]        LEN_R  = 4'(LEN_DEF);

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, TERM} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [11:0]       data_q, data_d;
  logic [3:0]        len_q, len_d;
  logic              wen_q, wen_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              en_q;
  logic [3:0]        note;
  logic              rest;
  logic [11:0]       word;

  always_comb begin
    note = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (SW[i-1]) note = 4'(i - 1);
    end
  end

  assign rest = (SW == '0);
  assign word = {rest, note, band_in, len_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !en_q) begin
          state_d = CAPTURE;
          ptr_d   = BASE_A;
        end
      end
      CAPTURE: begin
        // Leaving writing mode takes priority over any pulse in the same cycle.
        if (!enable) begin
          state_d = TERM;
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          data_d  = '0;
        end else if (commit) begin
          if (!full_q) begin
            state_d = WRITE;
            wen_d   = 1'b1;
            addr_d  = ptr_q;
            data_d  = word;
          end
        end else if (del && ptr_q != BASE_A) begin
          ptr_d = ptr_q - 1'b1;
        end
      end
      WRITE: begin
        ptr_d = ptr_q + 1'b1;
        if (!enable) begin
          state_d = TERM;
          wen_d   = 1'b1;
          addr_d  = ptr_q + 1'b1;
          data_d  = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      TERM: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d = len_q;
    if (enable && len_key) len_d = (len_q == 4'd15) ? 4'd1 : len_q + 4'd1;
  end

  assign count_d = ptr_d - BASE_A;
  assign full_d  = (ptr_d == LAST_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE_A;
      len_q   <= LEN_R;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= BASE_A;
      data_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      en_q    <= enable;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  assign addr_c = addr_q;
  assign data_c = data_q;
  assign wen_c  = wen_q;
  assign count  = count_q;
  assign len    = len_q;
  assign full   = full_q;
  assign done   = done_q;

endmodule

// File: tb/tb_score_writer.sv
// Bench for score_writer: a song-queue reference model is compared against the DUT every cycle,
// together with directed scenarios that use literal expected values.
module tb_score_writer;

  localparam int DEPTH   = 4;
  localparam int LEN_DEF = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] SW;
  logic [2:0]  band_in;
  logic        commit, del, len_key;
  logic [15:0] addr_c;
  logic [11:0] data_c;
  logic        wen_c;
  logic [15:0] count;
  logic [3:0]  len;
  logic        full, done;

  int checks = 0;
  int errors = 0;

  score_writer #(.ADDR_W(16), .BASE(0), .DEPTH(DEPTH), .LEN_DEF(LEN_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .SW(SW), .band_in(band_in),
    .commit(commit), .del(del), .len_key(len_key),
    .addr_c(addr_c), .data_c(data_c), .wen_c(wen_c), .count(count),
    .len(len), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mkword(input logic [15:0] sw, input int bnd, input int ln);
    int n;
    n = -1;
    for (int i = 0; i < 16; i++) if (sw[i] && n < 0) n = i;
    if (n < 0) return 2048 + bnd * 16 + ln;
    return n * 128 + bnd * 16 + ln;
  endfunction

  // Reference model: the song is a queue of stored words, so the pointer is its size.
  int song[$];
  bit active, busy, term_pending, prev_en;
  int m_len, e_addr, e_data;
  bit e_wen, e_done;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      song.delete();
      active = 0; busy = 0; term_pending = 0; prev_en = 0;
      m_len = LEN_DEF; e_addr = 0; e_data = 0; e_wen = 0; e_done = 0;
    end else begin
      e_wen = 0;
      e_done = 0;
      if (term_pending) begin
        term_pending = 0;
        e_done = 1;
        active = 0;
      end else if (busy) begin
        busy = 0;
        if (!enable) begin
          e_wen = 1; e_addr = song.size(); e_data = 0; term_pending = 1;
        end
      end else if (active) begin
        if (!enable) begin
          e_wen = 1; e_addr = song.size(); e_data = 0; term_pending = 1;
        end else if (commit) begin
          if (song.size() < DEPTH - 1) begin
            e_wen = 1; e_addr = song.size(); e_data = mkword(SW, int'(band_in), m_len);
            song.push_back(e_data);
            busy = 1;
          end
        end else if (del && song.size() > 0) begin
          void'(song.pop_back());
        end
      end else if (enable && !prev_en) begin
        active = 1;
        song.delete();
      end
      if (enable && len_key) m_len = (m_len == 15) ? 1 : m_len + 1;
      prev_en = enable;
    end
  end

  // Per-cycle comparison on the falling edge.
  initial forever begin
    int c;
    @(negedge clk);
    c = song.size() - int'(busy);
    chk("wen_c", wen_c, e_wen);
    chk("addr_c", addr_c, e_addr);
    chk("data_c", data_c, e_data);
    chk("count", count, c);
    chk("len", len, m_len);
    chk("full", full, c == DEPTH - 1);
    chk("done", done, e_done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic c, input logic d, input logic k);
    commit = c; del = d; len_key = k;
    tick();
    commit = 0; del = 0; len_key = 0;
  endtask

  initial begin
    rst_n = 0; enable = 0; SW = '0; band_in = 3'd3;
    commit = 0; del = 0; len_key = 0;
    repeat (3) tick();
    chk("rst_wen", wen_c, 0);
    chk("rst_addr", addr_c, 0);
    chk("rst_data", data_c, 0);
    chk("rst_count", count, 0);
    chk("rst_len", len, LEN_DEF);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    rst_n = 1;

    // First note word
    enable = 1; SW = 16'h0004;
    tick();
    pulse(1, 0, 0);
    chk("t1_wen", wen_c, 1);
    chk("t1_addr", addr_c, 0);
    chk("t1_data", data_c, 12'h134);
    tick();
    chk("t1_wen_drop", wen_c, 0);
    chk("t1_count", count, 1);

    // Rest word with longer length, then length wrap
    SW = '0;
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    chk("t2_len6", len, 6);
    pulse(1, 0, 0);
    chk("t2_addr", addr_c, 1);
    chk("t2_data", data_c, 12'h836);
    tick();
    chk("t2_count", count, 2);
    repeat (10) pulse(0, 0, 1);
    chk("t2_len_wrap", len, 1);

    enable = 0;
    tick();
    chk("term_wen", wen_c, 1);
    chk("term_addr", addr_c, 2);
    chk("term_data", data_c, 0);
    tick();
    chk("term_done", done, 1);
    tick();
    chk("done_once", done, 0);

    // Three commits, step back, overwrite
    enable = 1; SW = 16'h0004;
    tick();
    repeat (3) begin
      pulse(1, 0, 0);
      tick();
    end
    chk("t3_count3", count, 3);
    chk("t3_full", full, 1);
    pulse(0, 1, 0);
    chk("t3_del_count", count, 2);
    chk("t3_del_full", full, 0);
    SW = 16'h8000;
    pulse(1, 0, 0);
    chk("t3_addr", addr_c, 2);
    chk("t3_data", data_c, 12'h7B1);
    tick();
    chk("t3_count", count, 3);

    // Commits while full are ignored; terminator still fits
    SW = 16'h0004;
    pulse(1, 0, 0);
    chk("t4_nowen", wen_c, 0);
    tick();
    pulse(1, 0, 0);
    chk("t4_nowen2", wen_c, 0);
    chk("t4_count", count, 3);
    enable = 0;
    tick();
    chk("t4_term_wen", wen_c, 1);
    chk("t4_term_addr", addr_c, 3);
    chk("t4_term_data", data_c, 0);
    tick();
    chk("t4_done", done, 1);

    // commit+del and commit+len_key arbitration
    tick();
    enable = 1;
    tick();
    pulse(1, 0, 0); tick();
    pulse(1, 0, 0); tick();
    pulse(1, 1, 0);
    chk("t5_wen", wen_c, 1);
    chk("t5_addr", addr_c, 2);
    chk("t5_data", data_c, 12'h131);
    tick();
    chk("t5_count", count, 3);
    pulse(0, 1, 0);
    chk("t5_del", count, 2);
    pulse(1, 0, 1);
    chk("t5_oldlen", data_c, 12'h131);
    chk("t5_newlen", len, 2);
    tick();

    // Reset during a write
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    chk("t6_wen_pre", wen_c, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_wen_rst", wen_c, 0);
    chk("t6_addr_rst", addr_c, 0);
    tick();
    rst_n = 1;
    chk("t6_count", count, 0);
    chk("t6_len", len, LEN_DEF);

    // Randomized traffic checked by the per-cycle comparison
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 4) enable = ~enable;
      commit  = ($urandom_range(99) < 35);
      del     = ($urandom_range(99) < 12);
      len_key = ($urandom_range(99) < 10);
      SW      = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      band_in = 3'($urandom);
      tick();
    end
    commit = 0; del = 0; len_key = 0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
